// File: rtl/eb1_lsu_addrchk_arb.sv
`default_nettype none
// ============================================================================
// Module   : eb1_lsu_addrchk_arb
// Purpose  : Arbitrates the LSU address-check slot between core and DMA,
//            with a forced DMA grant after a bounded run of lost cycles.
// Options  : LSU_ARB_PERF_EN adds perf_dma_stall / perf_force_cnt outputs.
// Revision : 1.0 - initial release
// ============================================================================
module eb1_lsu_addrchk_arb #(
  parameter int DMA_STARVE_MAX = 4,
  parameter int CNT_W          = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [31:0] core_addr,
  input  logic [1:0]  core_size,
  input  logic        core_store,
  input  logic        dma_req_valid,
  output logic        dma_req_ready,
  input  logic [31:0] dma_addr,
  input  logic [1:0]  dma_size,
  input  logic        dma_store,
  output logic        chk_valid,
  input  logic        chk_ready,
  output logic [31:0] chk_start_addr,
  output logic [31:0] chk_end_addr,
  output logic        chk_by,
  output logic        chk_half,
  output logic        chk_word,
  output logic        chk_store,
  output logic        chk_dma,
  input  logic        chk_access_fault,
  input  logic        chk_misalign_fault,
  output logic        dma_rsp_valid,
  output logic        dma_rsp_error
`ifdef LSU_ARB_PERF_EN
  ,
  output logic        perf_dma_stall,
  output logic [15:0] perf_force_cnt
`endif
);

  localparam logic [0:0]       c_st_arb     = 1'b0;
  localparam logic [0:0]       c_st_force   = 1'b1;
  localparam logic [CNT_W-1:0] c_starve_max = CNT_W'(DMA_STARVE_MAX);

  logic [0:0]       r_state;
  logic [0:0]       w_state_next;
  logic [CNT_W-1:0] r_starve_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  logic        r_out_valid;
  logic [31:0] r_start;
  logic [31:0] r_end;
  logic        r_by;
  logic        r_half;
  logic        r_word;
  logic        r_store;
  logic        r_dma;
  logic        r_rsp_valid;
  logic        r_rsp_error;

  logic        w_slot_open;
  logic        w_core_elig;
  logic        w_core_grant;
  logic        w_dma_grant;
  logic        w_take;
  logic [31:0] w_sel_addr;
  logic [1:0]  w_sel_size;
  logic        w_sel_store;
  logic        w_sz_by;
  logic        w_sz_half;
  logic        w_sz_word;
  logic [1:0]  w_end_off;
  logic        w_handshake;

  // Nothing is granted while reset is asserted so readies read 0 in reset.
  assign w_slot_open = ~rst & (~r_out_valid | chk_ready);
  assign w_core_elig = core_req_valid & ~flush;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= c_st_arb;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_next;
      r_starve_cnt <= w_cnt_next;
    end
  end

  // Next-state and starvation counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_starve_cnt;
    if (w_dma_grant || !dma_req_valid) begin
      w_cnt_next = '0;
    end else if (r_starve_cnt != c_starve_max) begin
      w_cnt_next = r_starve_cnt + 1'b1;
    end
    case (r_state)
      c_st_arb: begin
        if (dma_req_valid && !w_dma_grant && (w_cnt_next == c_starve_max)) begin
          w_state_next = c_st_force;
        end
      end
      c_st_force: begin
        if (w_dma_grant || !dma_req_valid) begin
          w_state_next = c_st_arb;
        end
      end
      default: w_state_next = c_st_arb;
    endcase
  end

  // Grant outputs: core first, except a pending DMA wins while forced.
  always_comb begin
    w_core_grant = 1'b0;
    w_dma_grant  = 1'b0;
    if (w_slot_open) begin
      if ((r_state == c_st_force) && dma_req_valid) begin
        w_dma_grant = 1'b1;
      end else if (w_core_elig) begin
        w_core_grant = 1'b1;
      end else if (dma_req_valid) begin
        w_dma_grant = 1'b1;
      end
    end
  end

  assign core_req_ready = w_core_grant;
  assign dma_req_ready  = w_dma_grant;
  assign w_take         = w_core_grant | w_dma_grant;

  assign w_sel_addr  = w_dma_grant ? dma_addr  : core_addr;
  assign w_sel_size  = w_dma_grant ? dma_size  : core_size;
  assign w_sel_store = w_dma_grant ? dma_store : core_store;

  // Size 3 is folded into word.
  assign w_sz_by   = (w_sel_size == 2'd0);
  assign w_sz_half = (w_sel_size == 2'd1);
  assign w_sz_word = w_sel_size[1];
  assign w_end_off = {w_sz_word, w_sz_word | w_sz_half};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_start     <= '0;
      r_end       <= '0;
      r_by        <= 1'b0;
      r_half      <= 1'b0;
      r_word      <= 1'b0;
      r_store     <= 1'b0;
      r_dma       <= 1'b0;
    end else if (w_take) begin
      r_out_valid <= 1'b1;
      r_start     <= w_sel_addr;
      r_end       <= w_sel_addr + {30'd0, w_end_off};
      r_by        <= w_sz_by;
      r_half      <= w_sz_half;
      r_word      <= w_sz_word;
      r_store     <= w_sel_store;
      r_dma       <= w_dma_grant;
    end else if (r_out_valid && (chk_ready || (flush && !r_dma))) begin
      r_out_valid <= 1'b0;
    end
  end

  assign w_handshake = r_out_valid & chk_ready & r_dma;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= w_handshake;
      r_rsp_error <= w_handshake & (chk_access_fault | chk_misalign_fault);
    end
  end

  assign chk_valid      = r_out_valid;
  assign chk_start_addr = r_start;
  assign chk_end_addr   = r_end;
  assign chk_by         = r_by;
  assign chk_half       = r_half;
  assign chk_word       = r_word;
  assign chk_store      = r_store;
  assign chk_dma        = r_dma;
  assign dma_rsp_valid  = r_rsp_valid;
  assign dma_rsp_error  = r_rsp_error;

`ifdef LSU_ARB_PERF_EN
  logic [15:0] r_perf_force_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_force_cnt <= '0;
    end else if ((r_state == c_st_force) && w_dma_grant && (r_perf_force_cnt != 16'hFFFF)) begin
      r_perf_force_cnt <= r_perf_force_cnt + 16'd1;
    end
  end

  assign perf_dma_stall = dma_req_valid & ~w_dma_grant;
  assign perf_force_cnt = r_perf_force_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_eb1_lsu_addrchk_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_eb1_lsu_addrchk_arb
// Purpose  : Directed self-checking bench for eb1_lsu_addrchk_arb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eb1_lsu_addrchk_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [31:0] core_addr;
  logic [1:0]  core_size;
  logic        core_store;
  logic        dma_req_valid;
  logic        dma_req_ready;
  logic [31:0] dma_addr;
  logic [1:0]  dma_size;
  logic        dma_store;
  logic        chk_valid;
  logic        chk_ready;
  logic [31:0] chk_start_addr;
  logic [31:0] chk_end_addr;
  logic        chk_by;
  logic        chk_half;
  logic        chk_word;
  logic        chk_store;
  logic        chk_dma;
  logic        chk_access_fault;
  logic        chk_misalign_fault;
  logic        dma_rsp_valid;
  logic        dma_rsp_error;

  int n_checks = 0;
  int n_pass   = 0;

  eb1_lsu_addrchk_arb #(.DMA_STARVE_MAX(4), .CNT_W(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .flush              (flush),
    .core_req_valid     (core_req_valid),
    .core_req_ready     (core_req_ready),
    .core_addr          (core_addr),
    .core_size          (core_size),
    .core_store         (core_store),
    .dma_req_valid      (dma_req_valid),
    .dma_req_ready      (dma_req_ready),
    .dma_addr           (dma_addr),
    .dma_size           (dma_size),
    .dma_store          (dma_store),
    .chk_valid          (chk_valid),
    .chk_ready          (chk_ready),
    .chk_start_addr     (chk_start_addr),
    .chk_end_addr       (chk_end_addr),
    .chk_by             (chk_by),
    .chk_half           (chk_half),
    .chk_word           (chk_word),
    .chk_store          (chk_store),
    .chk_dma            (chk_dma),
    .chk_access_fault   (chk_access_fault),
    .chk_misalign_fault (chk_misalign_fault),
    .dma_rsp_valid      (dma_rsp_valid),
    .dma_rsp_error      (dma_rsp_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    core_req_valid = 1'b0; core_addr = '0; core_size = '0; core_store = 1'b0;
    dma_req_valid = 1'b0;  dma_addr = '0;  dma_size = '0;  dma_store = 1'b0;
    chk_ready = 1'b0; chk_access_fault = 1'b0; chk_misalign_fault = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_chk_valid", 32'(chk_valid), 32'd0);
    check_eq("rst_rsp_valid", 32'(dma_rsp_valid), 32'd0);
    check_eq("rst_end_addr", chk_end_addr, 32'd0);
    rst = 1'b0;

    // Core-only word load
    core_req_valid = 1'b1; core_addr = 32'hF004_0000; core_size = 2'd2; chk_ready = 1'b1;
    #1;
    check_eq("t1_core_ready", 32'(core_req_ready), 32'd1);
    step();
    core_req_valid = 1'b0;
    check_eq("t1_chk_valid", 32'(chk_valid), 32'd1);
    check_eq("t1_start", chk_start_addr, 32'hF004_0000);
    check_eq("t1_end", chk_end_addr, 32'hF004_0003);
    check_eq("t1_word", 32'(chk_word), 32'd1);
    check_eq("t1_dma", 32'(chk_dma), 32'd0);
    step();
    check_eq("t1_drained", 32'(chk_valid), 32'd0);

    // Starvation: DMA forced in on the 5th contended cycle
    core_req_valid = 1'b1; core_addr = 32'h0000_2000; core_size = 2'd2;
    dma_req_valid = 1'b1;  dma_addr = 32'h0000_0100;  dma_size = 2'd2;
    for (int i = 1; i <= 6; i++) begin
      #1;
      check_eq($sformatf("t2_core_ready_%0d", i), 32'(core_req_ready), 32'(i != 5));
      check_eq($sformatf("t2_dma_ready_%0d", i), 32'(dma_req_ready), 32'(i == 5));
      step();
      check_eq($sformatf("t2_chk_dma_%0d", i), 32'(chk_dma), 32'(i == 5));
    end
    core_req_valid = 1'b0; dma_req_valid = 1'b0;
    step();
    step();

    // DMA half write with access fault
    dma_req_valid = 1'b1; dma_addr = 32'h0000_0001; dma_size = 2'd1; dma_store = 1'b1;
    #1;
    check_eq("t3_dma_ready", 32'(dma_req_ready), 32'd1);
    step();
    dma_req_valid = 1'b0; chk_access_fault = 1'b1;
    #1;
    check_eq("t3_chk_valid", 32'(chk_valid), 32'd1);
    check_eq("t3_chk_dma", 32'(chk_dma), 32'd1);
    check_eq("t3_half", 32'(chk_half), 32'd1);
    check_eq("t3_end", chk_end_addr, 32'h0000_0002);
    check_eq("t3_store", 32'(chk_store), 32'd1);
    check_eq("t3_rsp_early", 32'(dma_rsp_valid), 32'd0);
    step();
    chk_access_fault = 1'b0;
    check_eq("t3_rsp_valid", 32'(dma_rsp_valid), 32'd1);
    check_eq("t3_rsp_error", 32'(dma_rsp_error), 32'd1);
    step();
    check_eq("t3_rsp_pulse", 32'(dma_rsp_valid), 32'd0);

    // Backpressure hold then flush
    chk_ready = 1'b0;
    core_req_valid = 1'b1; core_addr = 32'h1234_5678; core_size = 2'd0; core_store = 1'b1;
    #1;
    check_eq("t4_core_ready", 32'(core_req_ready), 32'd1);
    step();
    core_addr = 32'hAAAA_0000;
    check_eq("t4_byte", 32'(chk_by), 32'd1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq($sformatf("t4_hold_valid_%0d", i), 32'(chk_valid), 32'd1);
      check_eq($sformatf("t4_hold_start_%0d", i), chk_start_addr, 32'h1234_5678);
      check_eq($sformatf("t4_hold_end_%0d", i), chk_end_addr, 32'h1234_5678);
      check_eq($sformatf("t4_no_ready_%0d", i), 32'(core_req_ready), 32'd0);
      if (i == 2) begin
        flush = 1'b1;
        core_req_valid = 1'b0;
      end
      step();
    end
    flush = 1'b0;
    check_eq("t4_flushed", 32'(chk_valid), 32'd0);

    // Address wrap, including the illegal size folded to word
    chk_ready = 1'b1; core_store = 1'b0;
    core_req_valid = 1'b1; core_addr = 32'hFFFF_FFFE; core_size = 2'd2;
    step();
    check_eq("t5_start", chk_start_addr, 32'hFFFF_FFFE);
    check_eq("t5_end_wrap", chk_end_addr, 32'h0000_0001);
    core_addr = 32'hFFFF_FFFF; core_size = 2'd3;
    step();
    check_eq("t5_end_sz3", chk_end_addr, 32'h0000_0002);
    check_eq("t5_word_sz3", 32'(chk_word), 32'd1);
    core_req_valid = 1'b0;
    step();

    // Reset while a DMA entry is held
    chk_ready = 1'b0;
    dma_req_valid = 1'b1; dma_addr = 32'h0000_0040; dma_size = 2'd2; dma_store = 1'b0;
    step();
    step();
    step();
    check_eq("t6_held", 32'(chk_valid), 32'd1);
    check_eq("t6_cnt_pre", 32'(dut.r_starve_cnt), 32'd2);
    rst = 1'b1; chk_ready = 1'b1; dma_req_valid = 1'b0;
    #1;
    check_eq("t6_rst_valid", 32'(chk_valid), 32'd0);
    check_eq("t6_rst_cnt", 32'(dut.r_starve_cnt), 32'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t6_no_rsp_%0d", i), 32'(dma_rsp_valid), 32'd0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
